// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline register addresses and memory
// handshake in, stall/flush/forward controls and performance counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1D_addr_i;
    logic [4:0]       rs2D_addr_i;
    logic [4:0]       rs1E_addr_i;
    logic [4:0]       rs2E_addr_i;
    logic [4:0]       rdE_addr_i;
    logic             rdE_wr_ena_i;
    logic             loadE_i;
    logic [4:0]       rdM_addr_i;
    logic             rdM_wr_ena_i;
    logic [4:0]       rdW_addr_i;
    logic             rdW_wr_ena_i;
    logic             redirectE_i;
    logic             memM_req_i;
    logic             memM_ready_i;
    logic             stallF_o;
    logic             stallD_o;
    logic             stallE_o;
    logic             stallM_o;
    logic             flushD_o;
    logic             flushE_o;
    logic             flushW_o;
    logic [1:0]       fwdA_o;
    logic [1:0]       fwdB_o;
    logic             mem_timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output rs1D_addr_i, rs2D_addr_i, rs1E_addr_i, rs2E_addr_i,
        output rdE_addr_i, rdE_wr_ena_i, loadE_i,
        output rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i,
        output redirectE_i, memM_req_i, memM_ready_i,
        input  stallF_o, stallD_o, stallE_o, stallM_o,
        input  flushD_o, flushE_o, flushW_o,
        input  fwdA_o, fwdB_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  rs1D_addr_i, rs2D_addr_i, rs1E_addr_i, rs2E_addr_i,
        input  rdE_addr_i, rdE_wr_ena_i, loadE_i,
        input  rdM_addr_i, rdM_wr_ena_i, rdW_addr_i, rdW_wr_ena_i,
        input  redirectE_i, memM_req_i, memM_ready_i,
        output stallF_o, stallD_o, stallE_o, stallM_o,
        output flushD_o, flushE_o, flushW_o,
        output fwdA_o, fwdB_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core: stall/flush priority,
// operand forwarding, bounded memory-wait FSM and stall/flush counters.
//  state       | meaning
//  ST_RUN      | no outstanding stalled memory access
//  ST_MEM_WAIT | memory stage held waiting for ready, r_wait_cnt counts cycles
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_wait_cnt;
    logic [15:0]      w_wait_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_mem_pending;
    logic w_timeout;
    logic w_mem_stall;
    logic w_load_use;
    logic w_stall_fd;
    logic w_stall_em;
    logic w_flush_d;
    logic w_flush_e;
    logic w_flush_w;
    logic w_mem_timeout;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       m_we,
        input logic [4:0] m_rd,
        input logic       w_we,
        input logic [4:0] w_rd
    );
        if (m_we && (m_rd != 5'd0) && (m_rd == rs))      return 2'b10;
        else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
        else                                             return 2'b00;
    endfunction

    always_comb begin
        w_mem_pending = hz.memM_req_i && !hz.memM_ready_i;
        w_timeout     = (r_state == ST_MEM_WAIT) && w_mem_pending
                        && (r_wait_cnt == TIMEOUT_VAL);
        w_mem_stall   = w_mem_pending && !w_timeout;
        w_load_use    = hz.loadE_i && hz.rdE_wr_ena_i && (hz.rdE_addr_i != 5'd0)
                        && ((hz.rdE_addr_i == hz.rs1D_addr_i)
                            || (hz.rdE_addr_i == hz.rs2D_addr_i));
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 16'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_wait_cnt_nxt = r_wait_cnt + 16'd1;
                end else begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 16'd0;
            end
        endcase
    end

    // Redirect and load-use are only seen once the memory stall drops.
    always_comb begin
        w_stall_fd    = 1'b0;
        w_stall_em    = 1'b0;
        w_flush_d     = 1'b0;
        w_flush_e     = 1'b0;
        w_flush_w     = 1'b0;
        w_mem_timeout = 1'b0;
        w_fwd_a       = 2'b00;
        w_fwd_b       = 2'b00;
        if (!rst_i) begin
            w_mem_timeout = w_timeout;
            w_fwd_a = fwd_sel(hz.rs1E_addr_i, hz.rdM_wr_ena_i, hz.rdM_addr_i,
                              hz.rdW_wr_ena_i, hz.rdW_addr_i);
            w_fwd_b = fwd_sel(hz.rs2E_addr_i, hz.rdM_wr_ena_i, hz.rdM_addr_i,
                              hz.rdW_wr_ena_i, hz.rdW_addr_i);
            if (w_mem_stall) begin
                w_stall_fd = 1'b1;
                w_stall_em = 1'b1;
                w_flush_w  = 1'b1;
            end else if (hz.redirectE_i) begin
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else if (w_load_use) begin
                w_stall_fd = 1'b1;
                w_flush_e  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 16'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_stall_fd) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush_d)  r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign hz.stallF_o      = w_stall_fd;
    assign hz.stallD_o      = w_stall_fd;
    assign hz.stallE_o      = w_stall_em;
    assign hz.stallM_o      = w_stall_em;
    assign hz.flushD_o      = w_flush_d;
    assign hz.flushE_o      = w_flush_e;
    assign hz.flushW_o      = w_flush_w;
    assign hz.fwdA_o        = w_fwd_a;
    assign hz.fwdB_o        = w_fwd_b;
    assign hz.mem_timeout_o = w_mem_timeout;
    assign hz.stall_cnt_o   = r_stall_cnt;
    assign hz.flush_cnt_o   = r_flush_cnt;
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It watches the register addresses of the instructions in decode, execute, memory and writeback, the execute-stage redirect and the memory-stage data handshake. From these it drives the per-stage stall/flush controls (including the `flushE` bubble into the ID/EX register) and the execute-stage operand forwarding selects. It also owns a bounded memory-wait FSM with timeout, plus stall and flush performance counters.

## Interface
- `MEM_TIMEOUT`, 16: maximum consecutive stalled cycles on one memory access; legal range ≥2.
- `CNT_W`, 32: width of the performance counters.

- `clk_i`  in  1  core clock
- `rst_i`  in  1  synchronous, active-high reset
- `rs1D_addr_i`, `rs2D_addr_i`  in  5  source registers of the instruction in decode
- `rs1E_addr_i`, `rs2E_addr_i`  in  5  source registers of the instruction in execute
- `rdE_addr_i`  in  5, `rdE_wr_ena_i`  in  1, `loadE_i`  in  1  destination, write enable and load flag of the instruction in execute
- `rdM_addr_i`  in  5, `rdM_wr_ena_i`  in  1  destination and write enable of the instruction in memory
- `rdW_addr_i`  in  5, `rdW_wr_ena_i`  in  1  destination and write enable of the instruction in writeback
- `redirectE_i`  in  1  taken branch, JAL or JALR resolved in execute
- `memM_req_i`  in  1  memory-stage instruction accesses data memory
- `memM_ready_i`  in  1  data memory completes the access this cycle
- `stallF_o`, `stallD_o`, `stallE_o`, `stallM_o`  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers
- `flushD_o`  out  1  load a NOP into IF/ID
- `flushE_o`  out  1  load a bubble into ID/EX
- `flushW_o`  out  1  load a bubble into MEM/WB
- `fwdA_o`, `fwdB_o`  out  2  operand select: 00 register file, 01 WB result, 10 MEM result
- `mem_timeout_o`  out  1  one-cycle pulse when a memory wait is force-released
- `stall_cnt_o`, `flush_cnt_o`  out  CNT_W  performance counters

## Operation
- **FSM states:** RUN, MEM_WAIT. A 16-bit `wait_cnt` register backs the timeout.
- **Memory stall (priority 1):**
  - Condition: `memM_req_i & !memM_ready_i`, and not timed out.
  - Outputs: all four stall outputs = 1, `flushW_o` = 1, `flushD_o` = `flushE_o` = 0.
  - Redirect and load-use are deferred. EX is frozen, so their conditions persist and are re-evaluated after the stall.
- **Redirect (priority 2):** `redirectE_i` gives `flushD_o` = `flushE_o` = 1 and no stalls. A load-use hazard raised in the same cycle is suppressed, because the decode instruction is being flushed.
- **Load-use (priority 3):**
  - Condition: `loadE_i & rdE_wr_ena_i & rdE_addr_i != 0`, and `rdE_addr_i` equals `rs1D_addr_i` or `rs2D_addr_i`.
  - Outputs: `stallF_o` = `stallD_o` = 1 and `flushE_o` = 1. Lasts exactly one cycle.
- **Forwarding for operand A** (B is identical with `rs2E_addr_i`):
  - 10 if `rdM_wr_ena_i & rdM_addr_i != 0 & rdM_addr_i == rs1E_addr_i`;
  - else 01 if the same test passes on the W stage;
  - else 00.
  - MEM has priority over WB. x0 is never forwarded.
- **FSM transitions:**
  - RUN → MEM_WAIT when `memM_req_i & !memM_ready_i`; `wait_cnt` ← 1.
  - MEM_WAIT with `memM_ready_i` → RUN; `wait_cnt` ← 0. The stall is already deasserted in this cycle.
  - MEM_WAIT with no ready and `wait_cnt < MEM_TIMEOUT` → stay, `wait_cnt` increments.
  - MEM_WAIT with `wait_cnt == MEM_TIMEOUT` and no ready:
    - `mem_timeout_o` = 1 and all stall outputs and `flushW_o` = 0 in that cycle (forced release);
    - next state RUN, `wait_cnt` ← 0.
    - The following cycle is a new MEM instruction, so the FSM may legally re-enter MEM_WAIT.
- **Counters:** `stall_cnt_o` +1 each cycle `stallF_o` = 1; `flush_cnt_o` +1 each cycle `flushD_o` = 1. Both wrap modulo 2^CNT_W.

## Timing
- Stall, flush, forwarding and `mem_timeout_o` outputs are combinational from inputs and state: zero-cycle latency, valid in the same cycle.
- State, `wait_cnt` and both counters update on the rising edge of `clk_i`.
- While `rst_i` = 1:
  - all stall/flush outputs, `fwdA_o`/`fwdB_o` and `mem_timeout_o` are forced to 0;
  - on the clock edge, state ← RUN, `wait_cnt` ← 0 and both counters ← 0.
- Reset asserted mid MEM_WAIT abandons the wait with no `mem_timeout_o` pulse.
- A memory stall lasting N < MEM_TIMEOUT cycles adds exactly N to `stall_cnt_o`. A timed-out access adds exactly MEM_TIMEOUT.
- Redirect and memory stall in the same cycle: stall wins. The flush fires in the first cycle the stall drops, as long as `redirectE_i` is still high.
- Load-use and redirect in the same cycle: only the redirect takes effect; `stall_cnt_o` is unchanged.

## Test plan
- Load-use: `loadE_i`=1, `rdE_addr_i`=5, `rs2D_addr_i`=5 → one cycle with `stallF_o`/`stallD_o`/`flushE_o`=1, then 0; `stall_cnt_o`=1. The same stimulus with `rdE_addr_i`=0 gives no stall.
- Forwarding: `rdM_addr_i`=`rdW_addr_i`=`rs1E_addr_i`=7, both write enables=1 → `fwdA_o`=10. Dropping `rdM_wr_ena_i` → 01. Setting the address to 0 → 00.
- Memory wait: `memM_req_i`=1 with `memM_ready_i` low for 3 cycles, then high → stalls and `flushW_o` for 3 cycles and none on the ready cycle; `stall_cnt_o`=3; FSM back in RUN.
- Timeout, MEM_TIMEOUT=4: ready held low → 4 stall cycles, then one cycle with `mem_timeout_o`=1 and stalls=0; `stall_cnt_o`=4.
- Redirect during memory stall, plus a coincident load-use hazard: no flush while stalled, one `flushD_o`/`flushE_o` cycle after ready, no load-use stall; `flush_cnt_o`=1.
- Reset on the third MEM_WAIT cycle → all outputs 0 during reset, counters 0 and state RUN afterwards, no `mem_timeout_o`.
